vga_timing_gen_param: RTL and testbench
=======================================

Name: vga_timing_gen_param

Overview:
Parametrised VGA raster engine, replacing the fixed-format VGA front end.
- Generates the pixel-tick enable, horizontal and vertical counters, sync pulses and blanking.
- Registers the upstream colour (text/graphics generator) into a blank-forced RGB output stage.
- Provides a frame-locked blink signal for cursor/alarm flashing.
- Sits between the 50 MHz system clock domain and the VGA connector; text_top-style generators consume pixel_x/pixel_y and return rgb_in.

Parameters:
- DIV, 2, clk cycles per pixel (1 to 16); 2 gives 25 MHz from 50 MHz
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
- CNT_W, 10, counter and pixel coordinate width
- R_W, 3, red width
- G_W, 3, green width
- B_W, 2, blue width
- BLINK_FRAMES, 30, frames per blink half-period

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rgb_in  in  R_W+G_W+B_W  colour for current pixel_x/pixel_y, packed {r,g,b}; combinational from upstream
- pixel_tick  out  1  one-clk enable per pixel
- pixel_x  out  CNT_W  current horizontal count
- pixel_y  out  CNT_W  current vertical count
- video_on  out  1  registered; high when red/green/blue carry visible data
- hsync  out  1  registered horizontal sync
- vsync  out  1  registered vertical sync
- frame_start  out  1  one-clk pulse on the last pixel of the frame
- blink  out  1  frame-locked square wave
- red  out  R_W  registered red
- green  out  G_W  registered green
- blue  out  B_W  registered blue

Behaviour:
- Reset values:
  - Divider, counters, pixel_x, pixel_y: 0.
  - pixel_tick, video_on, frame_start, blink: 0.
  - red, green, blue: 0.
  - hsync = ~HS_POL; vsync = ~VS_POL (inactive levels).
- Reset is synchronous, wins over all other activity in the same cycle, and may arrive mid-frame.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Both must fit CNT_W; elaboration error otherwise.
- Tick divider:
  - div_cnt counts 0..DIV-1.
  - pixel_tick is high for the clk cycle where div_cnt == DIV-1.
  - DIV=1: pixel_tick held high from the first cycle after reset.
- Counters (advance only on pixel_tick):
  - h wraps H_TOTAL-1 to 0.
  - v increments on the h wrap and wraps V_TOTAL-1 to 0.
  - pixel_x = h; pixel_y = v, with zero latency.
- Region decode from current h/v:
  - act = (h < H_ACTIVE) && (v < V_ACTIVE)
  - hs_act = h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]
  - vs_act = v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]
- Output stage (updates on pixel_tick, otherwise holds):
  - hsync <= hs_act ? HS_POL : ~HS_POL; vsync likewise with VS_POL.
  - video_on <= act.
  - {red,green,blue} <= act ? rgb_in : 0.
  - Net latency is one pixel from counters to pins; sync and colour stay mutually aligned.
- frame_start: high for exactly one clk, coincident with pixel_tick, when h = H_TOTAL-1 and v = V_TOTAL-1.
- Blink:
  - fcnt increments on frame_start.
  - At BLINK_FRAMES-1 with frame_start, fcnt clears and blink toggles.
  - Period = 2*BLINK_FRAMES frames.
- rgb_in is sampled only on pixel_tick; changes between ticks are ignored.

Optional Feature:
- VGA_BORDER_EN
- Defined:
  - Adds parameter BORDER_RGB (default all ones).
  - When act and (h==0 || h==H_ACTIVE-1 || v==0 || v==V_ACTIVE-1), the output stage loads BORDER_RGB instead of rgb_in.
  - Timing and latency are unchanged.
- Undefined: no border logic; the output always uses rgb_in when act.

Test Plan:
- Default params, release reset → pixel_tick every 2nd clk; h reaches 799 then 0; v increments at that wrap; frame_start pulses once per 800*525 ticks.
- Default params → hsync low from the tick after h=656 through the tick after h=751 (96 pixels); vsync low for v=490..491 (2 lines, delayed one pixel); both high elsewhere.
- rgb_in=8'hFF constant:
  - red/green/blue = all ones with video_on=1 for 640 pixels per line on lines 0..479.
  - Outputs are 0 with video_on=0 for h≥640 and for v≥480.
- Assert reset at h=300, v=200 for one clk → next cycle: counters 0, outputs 0, hsync/vsync inactive, blink 0; counting restarts cleanly.
- BLINK_FRAMES=2, DIV=1, small timing (H_ACTIVE=8, fronts/syncs/backs 1–2) → blink toggles every 2nd frame_start; period 4 frames.
- VGA_BORDER_EN defined, rgb_in=0 → pixels (0,y), (639,y), (x,0), (x,479) output BORDER_RGB; interior pixels output 0.

Source files
------------

// File: rtl/vga_timing_gen_param.sv
// vga_timing_gen_param: parametrised VGA raster engine.
// Generates the pixel-tick enable, the h/v counters, sync pulses and blanking.
// It registers the upstream colour into a blank-forced RGB stage and drives a
// frame-locked blink signal.
// Optional feature macro: VGA_BORDER_EN. When it is defined, the outermost
// visible ring of pixels is painted BORDER_RGB.
module vga_timing_gen_param #(
    parameter int DIV          = 2,
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int HS_POL       = 0,
    parameter int VS_POL       = 0,
    parameter int CNT_W        = 10,
    parameter int R_W          = 3,
    parameter int G_W          = 3,
    parameter int B_W          = 2,
    parameter int BLINK_FRAMES = 30
`ifdef VGA_BORDER_EN
    ,
    parameter logic [R_W+G_W+B_W-1:0] BORDER_RGB = '1
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [R_W+G_W+B_W-1:0] rgb_in,
    output logic                   pixel_tick,
    output logic [CNT_W-1:0]       pixel_x,
    output logic [CNT_W-1:0]       pixel_y,
    output logic                   video_on,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   frame_start,
    output logic                   blink,
    output logic [R_W-1:0]         red,
    output logic [G_W-1:0]         green,
    output logic [B_W-1:0]         blue
);

    localparam int RGB_W   = R_W + G_W + B_W;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Every constant is sized to the signal it is compared against.
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [FC_W-1:0]  FC_LAST    = FC_W'(BLINK_FRAMES - 1);
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic             HS_ON      = HS_POL[0];
    localparam logic             VS_ON      = VS_POL[0];

    // Refuse to elaborate when the raster does not fit the counters.
    if ((H_TOTAL > (1 << CNT_W)) || (V_TOTAL > (1 << CNT_W)) || (DIV < 1) || (DIV > 16)) begin : g_bad_cfg
        $error("vga_timing_gen_param: totals exceed CNT_W or DIV out of range");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic             run_q, run_d;
    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic             blink_q, blink_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d;
    logic             video_on_q, video_on_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;

    logic             tick, h_wrap, v_wrap, frame_end, act, hs_act, vs_act;
    logic [RGB_W-1:0] pix;

    // run_q keeps the tick low during reset, which matters when DIV=1.
    assign tick      = run_q && (div_q == DIV_LAST);
    assign h_wrap    = (h_q == H_LAST);
    assign v_wrap    = (v_q == V_LAST);
    assign frame_end = tick && h_wrap && v_wrap;
    assign act       = (h_q < H_ACT) && (v_q < V_ACT);
    assign hs_act    = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
    assign vs_act    = (v_q >= VS_FIRST) && (v_q <= VS_LAST);

`ifdef VGA_BORDER_EN
    logic edge_px;
    assign edge_px = (h_q == '0) || (h_q == H_ACT - 1'b1) || (v_q == '0) || (v_q == V_ACT - 1'b1);
    assign pix     = edge_px ? BORDER_RGB : rgb_in;
`else
    assign pix     = rgb_in;
`endif

    // Next-state logic: divider free-runs, everything else advances on the tick.
    always_comb begin
        div_d      = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        run_d      = 1'b1;
        h_d        = h_q;
        v_d        = v_q;
        fcnt_d     = fcnt_q;
        blink_d    = blink_q;
        hsync_d    = hsync_q;
        vsync_d    = vsync_q;
        video_on_d = video_on_q;
        rgb_d      = rgb_q;
        if (tick) begin
            h_d = h_wrap ? '0 : h_q + 1'b1;
            if (h_wrap) begin
                v_d = v_wrap ? '0 : v_q + 1'b1;
            end
            // Decode of the current count lands on the pins one pixel later.
            hsync_d    = hs_act ? HS_ON : ~HS_ON;
            vsync_d    = vs_act ? VS_ON : ~VS_ON;
            video_on_d = act;
            rgb_d      = act ? pix : '0;
        end
        if (frame_end) begin
            if (fcnt_q == FC_LAST) begin
                fcnt_d  = '0;
                blink_d = ~blink_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // State register; reset overrides any tick in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q      <= '0;
            run_q      <= 1'b0;
            h_q        <= '0;
            v_q        <= '0;
            fcnt_q     <= '0;
            blink_q    <= 1'b0;
            hsync_q    <= ~HS_ON;
            vsync_q    <= ~VS_ON;
            video_on_q <= 1'b0;
            rgb_q      <= '0;
        end else begin
            div_q      <= div_d;
            run_q      <= run_d;
            h_q        <= h_d;
            v_q        <= v_d;
            fcnt_q     <= fcnt_d;
            blink_q    <= blink_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
            rgb_q      <= rgb_d;
        end
    end

    assign pixel_tick  = tick;
    assign pixel_x     = h_q;
    assign pixel_y     = v_q;
    assign frame_start = frame_end;
    assign blink       = blink_q;
    assign video_on    = video_on_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign red         = rgb_q[RGB_W-1 -: R_W];
    assign green       = rgb_q[G_W+B_W-1 -: G_W];
    assign blue        = rgb_q[B_W-1:0];

endmodule

// File: tb/tb_vga_timing_gen_param.sv
// tb_vga_timing_gen_param: directed bench for a reduced raster
// (15 x 10 pixels, DIV=2, blink every 2 frames).
// Expected registered outputs are queued when the tick is driven and popped
// after the edge.
module tb_vga_timing_gen_param;

    localparam int DIV = 2;
    localparam int HA  = 8;
    localparam int HF  = 2;
    localparam int HS  = 3;
    localparam int HB  = 2;
    localparam int VA  = 6;
    localparam int VF  = 1;
    localparam int VS  = 2;
    localparam int VB  = 1;
    localparam int BF  = 2;
    localparam int HT  = HA + HF + HS + HB;
    localparam int VT  = VA + VF + VS + VB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rgb_in = 8'h00;
    logic       pixel_tick, video_on, hsync, vsync, frame_start, blink;
    logic [9:0] pixel_x, pixel_y;
    logic [2:0] red, green;
    logic [1:0] blue;

    always #5 clk = ~clk;

    vga_timing_gen_param #(
        .DIV(DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(0), .VS_POL(0), .CNT_W(10), .R_W(3), .G_W(3), .B_W(2),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .reset(reset), .rgb_in(rgb_in),
        .pixel_tick(pixel_tick), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .video_on(video_on), .hsync(hsync), .vsync(vsync),
        .frame_start(frame_start), .blink(blink),
        .red(red), .green(green), .blue(blue)
    );

    typedef struct packed {
        logic       vo;
        logic       hs;
        logic       vs;
        logic [7:0] rgb;
    } exp_t;

    exp_t sb_q[$];
    exp_t exp_reg;
    int   m_div = 0, m_h = 0, m_v = 0, m_fcnt = 0;
    bit   m_run = 1'b0, m_blink = 1'b0;
    int   n_checks = 0, n_errors = 0;

    function automatic exp_t decode(int h, int v, logic [7:0] c);
        exp_t e;
        bit   act;
        act   = (h < HA) && (v < VA);
        e.vo  = act;
        e.hs  = (h >= HA + HF && h <= HA + HF + HS - 1) ? 1'b0 : 1'b1;
        e.vs  = (v >= VA + VF && v <= VA + VF + VS - 1) ? 1'b0 : 1'b1;
        e.rgb = act ? c : 8'h00;
`ifdef VGA_BORDER_EN
        if (act && (h == 0 || h == HA - 1 || v == 0 || v == VA - 1)) e.rgb = 8'hFF;
`endif
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, expv);
        end
    endtask

    // Advance the reference raster by one clk edge, given what was driven.
    task automatic advance(input bit r);
        bit t;
        t = m_run && (m_div == DIV - 1);
        if (r) begin
            m_div = 0; m_h = 0; m_v = 0; m_fcnt = 0; m_run = 0; m_blink = 0;
            exp_reg = '{vo: 1'b0, hs: 1'b1, vs: 1'b1, rgb: 8'h00};
            sb_q.delete();
        end else begin
            m_div = (m_div == DIV - 1) ? 0 : m_div + 1;
            m_run = 1'b1;
            if (t) begin
                if (sb_q.size() > 0) exp_reg = sb_q.pop_front();
                if (m_h == HT - 1 && m_v == VT - 1) begin
                    if (m_fcnt == BF - 1) begin
                        m_fcnt  = 0;
                        m_blink = ~m_blink;
                    end else begin
                        m_fcnt++;
                    end
                end
                if (m_h == HT - 1) begin
                    m_h = 0;
                    m_v = (m_v == VT - 1) ? 0 : m_v + 1;
                end else begin
                    m_h++;
                end
            end
        end
    endtask

    task automatic check_outputs();
        bit t_exp;
        t_exp = m_run && (m_div == DIV - 1);
        chk("pixel_tick",  32'(pixel_tick),  32'(t_exp));
        chk("pixel_x",     32'(pixel_x),     32'(m_h));
        chk("pixel_y",     32'(pixel_y),     32'(m_v));
        chk("frame_start", 32'(frame_start), 32'(t_exp && m_h == HT - 1 && m_v == VT - 1));
        chk("blink",       32'(blink),       32'(m_blink));
        chk("video_on",    32'(video_on),    32'(exp_reg.vo));
        chk("hsync",       32'(hsync),       32'(exp_reg.hs));
        chk("vsync",       32'(vsync),       32'(exp_reg.vs));
        chk("rgb",         32'({red, green, blue}), 32'(exp_reg.rgb));
    endtask

    // One clk: drive, queue the expectation if this cycle ticks, then check.
    task automatic step(input bit r, input logic [7:0] c);
        reset  = r;
        rgb_in = c;
        if (!r && m_run && (m_div == DIV - 1)) sb_q.push_back(decode(m_h, m_v, c));
        @(posedge clk);
        #1;
        advance(r);
        check_outputs();
    endtask

    initial begin
        int guard;
        // Reset held for three clks.
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom));
        // Two frames of random colour that changes every clk.
        for (int i = 0; i < 2 * HT * VT * DIV; i++) step(1'b0, 8'($urandom));
        // One frame of constant white.
        for (int i = 0; i < HT * VT * DIV; i++) step(1'b0, 8'hFF);
        // Run to a mid-frame point, then pulse reset for a single clk.
        guard = 0;
        while (!(m_h == 5 && m_v == 3) && guard < 2 * HT * VT * DIV) begin
            step(1'b0, 8'($urandom));
            guard++;
        end
        step(1'b1, 8'hFF);
        // Six more frames: the blink toggles every second frame.
        for (int i = 0; i < 6 * HT * VT * DIV; i++) step(1'b0, 8'($urandom));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
